// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one external B-bit adder among N requesters.
// Operands are latched on grant, and the result is returned with a one-cycle done pulse.
module adder_arbiter #(
  parameter int B  = 12,
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*B-1:0] a_in,
  input  logic [N*B-1:0] b_in,
  input  logic [N-1:0]   cin_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [B-1:0]   s_out,
  output logic           cout_out,
  output logic           busy,
  output logic [B-1:0]   add_a,
  output logic [B-1:0]   add_b,
  output logic           add_cin,
  input  logic [B-1:0]   add_s,
  input  logic           add_cout
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state_reg;
  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] owner_reg;
  logic [N-1:0]  gnt_reg;
  logic [N-1:0]  done_reg;
  logic [B-1:0]  s_reg;
  logic          cout_reg;
  logic [B-1:0]  a_reg;
  logic [B-1:0]  b_reg;
  logic          cin_reg;

  logic [PW-1:0] cand_idx [N];
  logic [B-1:0]  a_slice  [N];
  logic [B-1:0]  b_slice  [N];
  logic [PW-1:0] win_idx;
  logic          win_valid;
  logic [PW-1:0] ptr_next;

  // cand_idx[gi] is the requester examined at search offset gi from the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [PW:0] sum;
      assign sum          = {1'b0, ptr_reg} + (PW+1)'(gi);
      assign cand_idx[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
      assign a_slice[gi]  = a_in[gi*B +: B];
      assign b_slice[gi]  = b_in[gi*B +: B];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  assign ptr_next = (owner_reg == PW'(N - 1)) ? '0 : owner_reg + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            a_reg     <= a_slice[win_idx];
            b_reg     <= b_slice[win_idx];
            cin_reg   <= cin_in[win_idx];
            gnt_reg   <= N'(1) << win_idx;
            owner_reg <= win_idx;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          s_reg     <= add_s;
          cout_reg  <= add_cout;
          done_reg  <= gnt_reg;
          state_reg <= DONE;
        end
        DONE: begin
          done_reg  <= '0;
          gnt_reg   <= '0;
          ptr_reg   <= ptr_next;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt      = gnt_reg;
  assign done     = done_reg;
  assign s_out    = s_reg;
  assign cout_out = cout_reg;
  assign busy     = (state_reg != IDLE);
  assign add_a    = a_reg;
  assign add_b    = b_reg;
  assign add_cin  = cin_reg;

endmodule
